// File: rtl/zero_extend.sv
// zero_extend: keeps the low width_sel field of d_in and zero-fills above it; `ZEXT_SIGN_EXT_EN adds sign fill.
// Latency 1 cycle, one result per cycle, no backpressure: inputs are sampled on every rising edge.
module zero_extend #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_d_in,
  input  logic              i_enable,
  input  logic [1:0]        i_width_sel,
`ifdef ZEXT_SIGN_EXT_EN
  input  logic              i_sign_ext,
`endif
  output logic [DATA_W-1:0] o_d_out,
  output logic              o_trunc,
  output logic              o_valid_out
);

  localparam int Q = DATA_W / 4;
  localparam logic [DATA_W-1:0] MASK_Q1 = {{(DATA_W - Q){1'b0}}, {Q{1'b1}}};
  localparam logic [DATA_W-1:0] MASK_Q2 = {{(DATA_W - 2 * Q){1'b0}}, {(2 * Q){1'b1}}};
  localparam logic [DATA_W-1:0] MASK_Q3 = {{Q{1'b0}}, {(DATA_W - Q){1'b1}}};

  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_top;
  logic              w_msb;
  logic              w_sign;
  logic [DATA_W-1:0] w_fill;
  logic [DATA_W-1:0] w_nxt_d;
  logic              w_nxt_trunc;

  logic [DATA_W-1:0] r_d_out;
  logic              r_trunc;
  logic              r_valid;

`ifdef ZEXT_SIGN_EXT_EN
  assign w_sign = i_sign_ext;
`else
  assign w_sign = 1'b0;
`endif

  // w_mask marks the kept field; w_top isolates its MSB for the sign fill.
  always_comb begin
    w_mask = {DATA_W{1'b1}};
    case (i_width_sel)
      2'd0:    w_mask = MASK_Q1;
      2'd1:    w_mask = MASK_Q2;
      2'd2:    w_mask = MASK_Q3;
      default: w_mask = {DATA_W{1'b1}};
    endcase
  end

  assign w_top  = w_mask & ~(w_mask >> 1);
  assign w_msb  = |(i_d_in & w_top);
  assign w_fill = {DATA_W{w_sign & w_msb}};

  always_comb begin
    w_nxt_d     = i_d_in;
    w_nxt_trunc = 1'b0;
    if (i_enable) begin
      w_nxt_d     = (i_d_in & w_mask) | (w_fill & ~w_mask);
      w_nxt_trunc = |((i_d_in ^ w_fill) & ~w_mask);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d_out <= '0;
      r_trunc <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_d_out <= w_nxt_d;
      r_trunc <= w_nxt_trunc;
      r_valid <= 1'b1;
    end
  end

  assign o_d_out     = r_d_out;
  assign o_trunc     = r_trunc;
  assign o_valid_out = r_valid;

endmodule

// File: tb/tb_zero_extend.sv
// Bench for zero_extend: directed cases, randomized traffic against an arithmetic model, reset mid-stream.
`timescale 1ns/1ps
module tb_zero_extend;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] d_in;
  logic         enable;
  logic [1:0]   width_sel;
  logic         sign_ext;
  logic [W-1:0] d_out;
  logic         trunc;
  logic         valid_out;

  int checks;
  int failures;

  zero_extend #(.DATA_W(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_d_in      (d_in),
    .i_enable    (enable),
    .i_width_sel (width_sel),
`ifdef ZEXT_SIGN_EXT_EN
    .i_sign_ext  (sign_ext),
`endif
    .o_d_out     (d_out),
    .o_trunc     (trunc),
    .o_valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: field width F, keep d_in mod 2^F, fill the rest with zeros or copies of bit F-1.
  function automatic void model(input logic [W-1:0] din, input logic en, input logic [1:0] sel,
                                input logic sg, output logic [W-1:0] dout, output logic tr);
    int f;
    int field;
    int upper;
    int fillu;
    logic sg_eff;
`ifdef ZEXT_SIGN_EXT_EN
    sg_eff = sg;
`else
    sg_eff = 1'b0;
`endif
    if (!en) begin
      dout = din;
      tr   = 1'b0;
      return;
    end
    f     = (int'(sel) + 1) * W / 4;
    field = int'(din) % (1 << f);
    upper = int'(din) >> f;
    fillu = 0;
    if (sg_eff && din[f-1]) fillu = (1 << (W - f)) - 1;
    tr   = (upper != fillu);
    dout = W'(field + (fillu << f));
  endfunction

  // Drive on the falling edge, then land 1ns after the next rising edge for sampling.
  task automatic apply(input logic r, input logic [W-1:0] din, input logic en,
                       input logic [1:0] sel, input logic sg);
    @(negedge clk);
    rst       = r;
    d_in      = din;
    enable    = en;
    width_sel = sel;
    sign_ext  = sg;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 16'h4AA2, 1'b1, 2'd1, 1'b0);
      checks++;
      if (d_out !== 16'h0000) begin
        failures++;
        $display("FAIL reset_d_out edge%0d got=%h want=0000", i, d_out);
      end
      checks++;
      if (trunc !== 1'b0) begin
        failures++;
        $display("FAIL reset_trunc edge%0d got=%b want=0", i, trunc);
      end
      checks++;
      if (valid_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid edge%0d got=%b want=0", i, valid_out);
      end
    end
    apply(1'b0, 16'h4AA2, 1'b0, 2'd0, 1'b0);
    checks++;
    if (valid_out !== 1'b1) begin
      failures++;
      $display("FAIL release_valid got=%b want=1", valid_out);
    end
    checks++;
    if (d_out !== 16'h4AA2) begin
      failures++;
      $display("FAIL release_d_out got=%h want=4AA2", d_out);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] din_t [6] = '{16'h4AA2, 16'h4AA2, 16'h4AA2, 16'h4AA2, 16'h00A2, 16'h00A2};
    logic         en_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]   sel_t [6] = '{2'd1, 2'd1, 2'd0, 2'd3, 2'd1, 2'd1};
    logic         sg_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ZEXT_SIGN_EXT_EN
    logic [W-1:0] out_t [6] = '{16'h00A2, 16'h4AA2, 16'h0002, 16'h4AA2, 16'h00A2, 16'hFFA2};
    logic         tr_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    logic [W-1:0] out_t [6] = '{16'h00A2, 16'h4AA2, 16'h0002, 16'h4AA2, 16'h00A2, 16'h00A2};
    logic         tr_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, din_t[i], en_t[i], sel_t[i], sg_t[i]);
      checks++;
      if (d_out !== out_t[i]) begin
        failures++;
        $display("FAIL directed_d_out case%0d got=%h want=%h", i, d_out, out_t[i]);
      end
      checks++;
      if (trunc !== tr_t[i]) begin
        failures++;
        $display("FAIL directed_trunc case%0d got=%b want=%b", i, trunc, tr_t[i]);
      end
      checks++;
      if (valid_out !== 1'b1) begin
        failures++;
        $display("FAIL directed_valid case%0d got=%b want=1", i, valid_out);
      end
    end
  endtask

  task automatic test_random;
    logic         r;
    logic [W-1:0] din;
    logic         en;
    logic [1:0]   sel;
    logic         sg;
    logic [W-1:0] exp_d;
    logic         exp_t;
    logic         exp_v;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 15) == 0);
      din = W'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      sg  = 1'($urandom_range(0, 1));
      if (r) begin
        exp_d = '0;
        exp_t = 1'b0;
        exp_v = 1'b0;
      end else begin
        model(din, en, sel, sg, exp_d, exp_t);
        exp_v = 1'b1;
      end
      apply(r, din, en, sel, sg);
      checks++;
      if (d_out !== exp_d) begin
        failures++;
        $display("FAIL random_d_out iter%0d din=%h en=%b sel=%0d sg=%b got=%h want=%h",
                 i, din, en, sel, sg, d_out, exp_d);
      end
      checks++;
      if (trunc !== exp_t) begin
        failures++;
        $display("FAIL random_trunc iter%0d din=%h en=%b sel=%0d sg=%b got=%b want=%b",
                 i, din, en, sel, sg, trunc, exp_t);
      end
      checks++;
      if (valid_out !== exp_v) begin
        failures++;
        $display("FAIL random_valid iter%0d got=%b want=%b", i, valid_out, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] din_t [3] = '{16'h0001, 16'hFFFF, 16'h1234};
    logic [W-1:0] out_t [3] = '{16'h0001, 16'h00FF, 16'h0034};
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, din_t[i], 1'b1, 2'd1, 1'b0);
      checks++;
      if (d_out !== out_t[i]) begin
        failures++;
        $display("FAIL b2b_d_out step%0d got=%h want=%h", i, d_out, out_t[i]);
      end
    end
    apply(1'b1, 16'h5555, 1'b1, 2'd1, 1'b0);
    checks++;
    if (d_out !== 16'h0000) begin
      failures++;
      $display("FAIL b2b_rst_d_out got=%h want=0000", d_out);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rst_valid got=%b want=0", valid_out);
    end
    apply(1'b0, 16'h1234, 1'b1, 2'd1, 1'b0);
    checks++;
    if (d_out !== 16'h0034 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL b2b_resume got=%h/%b want=0034/1", d_out, valid_out);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    d_in      = 16'h4AA2;
    enable    = 1'b0;
    width_sel = 2'd0;
    sign_ext  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
